mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_if.sv | 32 +++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the three requester ports (index 0=d, 1=i, 2=x) and the memory port.
// Purely structural, no latency of its own.
// Flow control: valid/cack request handshake, busy/ready on the memory side.
interface mem_arbiter_if;
  logic [2:0]       p_valid;
  logic [2:0][19:0] p_addr;
  logic [2:0]       p_write;
  logic [2:0][15:0] p_wdata;
  logic [2:0]       p_cack;
  logic [2:0]       p_ready;
  logic [2:0][15:0] p_rdata;
  logic [2:0]       p_err;
  logic [19:0]      m_addr;
  logic [15:0]      m_wdata;
  logic             m_read;
  logic             m_write;
  logic [15:0]      m_rdata;
  logic             m_busy;
  logic             m_ready;

  // Arbiter side
  modport slave (
    input  p_valid, p_addr, p_write, p_wdata, m_rdata, m_busy, m_ready,
    output p_cack, p_ready, p_rdata, p_err, m_addr, m_wdata, m_read, m_write
  );

  // Requesters plus memory model side
  modport master (
    output p_valid, p_addr, p_write, p_wdata, m_rdata, m_busy, m_ready,
    input  p_cack, p_ready, p_rdata, p_err, m_addr, m_wdata, m_read, m_write
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between d, i and x requesters, with a watchdog.
// Latency: issue 1 cycle after IDLE sampling, p_ready 1 cycle after m_ready; 4-cycle minimum occupancy.
// Backpressure: m_busy stalls arbitration in IDLE; requests hold p_valid until their p_cack.
module mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state_q;
  logic [1:0]       last_q;
  logic [1:0]       idx_q;
  logic [19:0]      addr_q;
  logic [15:0]      wdata_q;
  logic             write_q;
  logic [TO_W-1:0]  wd_q;
  logic [2:0]       cack_q;
  logic [2:0]       ready_q;
  logic [2:0]       err_q;
  logic [2:0][15:0] rdata_q;
  logic             m_read_q;
  logic             m_write_q;

  logic [1:0]       cand1_d;
  logic [1:0]       cand2_d;
  logic [1:0]       win_d;
  logic [TO_W-1:0]  wd_inc_d;

  // Round-robin search starting one past the last winner; last winner itself is checked last.
  always_comb begin
    cand1_d  = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    cand2_d  = (cand1_d == 2'd2) ? 2'd0 : cand1_d + 2'd1;
    win_d    = last_q;
    if (bus.p_valid[cand1_d]) begin
      win_d = cand1_d;
    end else if (bus.p_valid[cand2_d]) begin
      win_d = cand2_d;
    end
    wd_inc_d = wd_q + 1'b1;
  end

  // Transaction FSM; every output is a register updated on the transition into the state that shows it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_q    <= 2'd2;
      idx_q     <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      wd_q      <= '0;
      cack_q    <= '0;
      ready_q   <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
    end else begin
      cack_q    <= '0;
      ready_q   <= '0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if ((|bus.p_valid) && !bus.m_busy) begin
            idx_q          <= win_d;
            last_q         <= win_d;
            addr_q         <= bus.p_addr[win_d];
            wdata_q        <= bus.p_wdata[win_d];
            write_q        <= bus.p_write[win_d];
            m_read_q       <= !bus.p_write[win_d];
            m_write_q      <= bus.p_write[win_d];
            cack_q[win_d]  <= 1'b1;
            state_q        <= ISSUE;
          end
        end
        ISSUE: begin
          wd_q    <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // A completion in the same cycle the watchdog expires takes priority over the abort.
          if (bus.m_ready) begin
            ready_q[idx_q] <= 1'b1;
            err_q[idx_q]   <= 1'b0;
            if (!write_q) begin
              rdata_q[idx_q] <= bus.m_rdata;
            end
            state_q <= DONE;
          end else begin
            if (wd_q != TO_W'(TIMEOUT)) begin
              wd_q <= wd_inc_d;
            end
            if (wd_inc_d == TO_W'(TIMEOUT)) begin
              ready_q[idx_q] <= 1'b1;
              err_q[idx_q]   <= 1'b1;
              rdata_q[idx_q] <= 16'hFFFF;
              state_q        <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.p_cack  = cack_q;
  assign bus.p_ready = ready_q;
  assign bus.p_err   = err_q;
  assign bus.p_rdata = rdata_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;
  assign bus.m_read  = m_read_q;
  assign bus.m_write = m_write_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector tables plus hand sequences for multi-cycle corners.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Memory side is driven directly by the bench.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(4), .TO_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rstn;
    logic [2:0]  valid;
    logic        busy;
    logic        mrdy;
    logic [15:0] mrd;
    logic [2:0]  exp_cack;
    logic [2:0]  exp_rdy;
    logic [2:0]  exp_err;
    logic        exp_rd;
    logic        exp_wr;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic rstn, logic [2:0] valid, logic busy, logic mrdy,
                              logic [15:0] mrd, logic [2:0] cack, logic [2:0] rdy,
                              logic rd, logic wr);
    vec_t v;
    v.rstn = rstn; v.valid = valid; v.busy = busy; v.mrdy = mrdy; v.mrd = mrd;
    v.exp_cack = cack; v.exp_rdy = rdy; v.exp_err = 3'b000; v.exp_rd = rd; v.exp_wr = wr;
    return v;
  endfunction

  // Each row: inputs live for one cycle, then the outputs after that edge are compared.
  task automatic run_vecs(input string tag);
    foreach (vq[j]) begin
      rst         = vq[j].rstn;
      bus.p_valid = vq[j].valid;
      bus.m_busy  = vq[j].busy;
      bus.m_ready = vq[j].mrdy;
      bus.m_rdata = vq[j].mrd;
      tick();
      chk($sformatf("%s[%0d] cack", tag, j), 32'(bus.p_cack),  32'(vq[j].exp_cack));
      chk($sformatf("%s[%0d] ready", tag, j), 32'(bus.p_ready), 32'(vq[j].exp_rdy));
      chk($sformatf("%s[%0d] err", tag, j), 32'(bus.p_err),   32'(vq[j].exp_err));
      chk($sformatf("%s[%0d] m_read", tag, j), 32'(bus.m_read),  32'(vq[j].exp_rd));
      chk($sformatf("%s[%0d] m_write", tag, j), 32'(bus.m_write), 32'(vq[j].exp_wr));
    end
    vq.delete();
  endtask

  initial begin
    rst         = 1'b0;
    bus.p_valid = '0;
    bus.p_addr[0] = 20'h01234;
    bus.p_addr[1] = 20'h0A000;
    bus.p_addr[2] = 20'hF0000;
    bus.p_write = 3'b000;
    bus.p_wdata[0] = 16'h1111;
    bus.p_wdata[1] = 16'h2222;
    bus.p_wdata[2] = 16'h5A5A;
    bus.m_rdata = '0;
    bus.m_busy  = 1'b0;
    bus.m_ready = 1'b0;

    // Single read on d, memory answers BEEF three cycles after the issue.
    vq.push_back(mk(1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 3'b001, 1'b0, 1'b0, 16'h0000, 3'b001, 3'b000, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 3'b000, 1'b0, 1'b0, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 3'b000, 1'b0, 1'b0, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 3'b000, 1'b0, 1'b0, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 3'b000, 1'b0, 1'b1, 16'hBEEF, 3'b000, 3'b001, 1'b0, 1'b0));
    vq.push_back(mk(1'b1, 3'b000, 1'b0, 1'b0, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0));
    run_vecs("read_d");
    chk("read_d m_addr", 32'(bus.m_addr), 32'h01234);
    chk("read_d d_rdata", 32'(bus.p_rdata[0]), 32'hBEEF);
    chk("read_d i_rdata", 32'(bus.p_rdata[1]), 32'h0000);
    chk("read_d x_rdata", 32'(bus.p_rdata[2]), 32'h0000);

    // All three requesting from reset, memory answers in the first WAIT cycle: d,i,x,d,i,x every 4 cycles.
    vq.push_back(mk(1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b0));
    for (int g = 0; g < 6; g++) begin
      logic [2:0] oh;
      oh = 3'(1 << (g % 3));
      vq.push_back(mk(1'b1, 3'b111, 1'b0, 1'b1, 16'h0D0D, oh,     3'b000, 1'b1, 1'b0));
      vq.push_back(mk(1'b1, 3'b111, 1'b0, 1'b1, 16'h0D0D, 3'b000, 3'b000, 1'b0, 1'b0));
      vq.push_back(mk(1'b1, 3'b111, 1'b0, 1'b1, 16'h0D0D, 3'b000, oh,     1'b0, 1'b0));
      vq.push_back(mk(1'b1, 3'b111, 1'b0, 1'b1, 16'h0D0D, 3'b000, 3'b000, 1'b0, 1'b0));
    end
    run_vecs("rr");
    for (int p = 0; p < 3; p++) chk($sformatf("rr rdata%0d", p), 32'(bus.p_rdata[p]), 32'h0D0D);

    // Write on x: one-cycle strobe, address/data held through WAIT, rdata untouched.
    bus.m_ready = 1'b0;
    bus.p_write = 3'b100;
    bus.p_valid = 3'b100;
    tick();
    chk("wr_x cack", 32'(bus.p_cack), 32'b100);
    chk("wr_x m_write", 32'(bus.m_write), 32'd1);
    chk("wr_x m_read", 32'(bus.m_read), 32'd0);
    bus.p_valid = 3'b000;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("wr_x m_write low", 32'(bus.m_write), 32'd0);
      chk("wr_x m_addr held", 32'(bus.m_addr), 32'hF0000);
      chk("wr_x m_wdata held", 32'(bus.m_wdata), 32'h5A5A);
    end
    bus.m_ready = 1'b1;
    bus.m_rdata = 16'hDEAD;
    tick();
    bus.m_ready = 1'b0;
    chk("wr_x ready", 32'(bus.p_ready), 32'b100);
    chk("wr_x rdata kept", 32'(bus.p_rdata[2]), 32'h0D0D);
    chk("wr_x err", 32'(bus.p_err), 32'b000);
    bus.p_write = 3'b000;
    tick();

    // Timeout on i with TIMEOUT=4: abort visible 6 cycles after the IDLE sample.
    bus.p_valid = 3'b010;
    tick();
    chk("to_i cack", 32'(bus.p_cack), 32'b010);
    bus.p_valid = 3'b000;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("to_i no ready yet", 32'(bus.p_ready), 32'b000);
    end
    tick();
    chk("to_i ready", 32'(bus.p_ready), 32'b010);
    chk("to_i err", 32'(bus.p_err), 32'b010);
    chk("to_i rdata", 32'(bus.p_rdata[1]), 32'hFFFF);
    tick();
    bus.m_ready = 1'b1;
    bus.m_rdata = 16'h7777;
    tick();
    bus.m_ready = 1'b0;
    chk("late ready ignored", 32'(bus.p_ready), 32'b000);
    chk("late err kept", 32'(bus.p_err), 32'b010);
    chk("late rdata kept", 32'(bus.p_rdata[1]), 32'hFFFF);

    // Next i read clears the error.
    bus.p_valid = 3'b010;
    tick();
    chk("i2 cack", 32'(bus.p_cack), 32'b010);
    bus.p_valid = 3'b000;
    tick();
    bus.m_ready = 1'b1;
    bus.m_rdata = 16'h1234;
    tick();
    bus.m_ready = 1'b0;
    chk("i2 ready", 32'(bus.p_ready), 32'b010);
    chk("i2 err cleared", 32'(bus.p_err), 32'b000);
    chk("i2 rdata", 32'(bus.p_rdata[1]), 32'h1234);
    tick();

    // m_ready in the very cycle the watchdog reaches TIMEOUT wins without error.
    bus.p_valid = 3'b001;
    tick();
    chk("edge cack", 32'(bus.p_cack), 32'b001);
    bus.p_valid = 3'b000;
    for (int c = 0; c < 4; c++) tick();
    chk("edge no early ready", 32'(bus.p_ready), 32'b000);
    bus.m_ready = 1'b1;
    bus.m_rdata = 16'hC0DE;
    tick();
    bus.m_ready = 1'b0;
    chk("edge ready", 32'(bus.p_ready), 32'b001);
    chk("edge err", 32'(bus.p_err), 32'b000);
    chk("edge rdata", 32'(bus.p_rdata[0]), 32'hC0DE);
    tick();

    // m_busy high for 10 cycles stalls; issue shows 2 cycles after the last busy cycle.
    bus.m_busy  = 1'b1;
    bus.p_valid = 3'b001;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("busy no cack", 32'(bus.p_cack), 32'b000);
      chk("busy no issue", 32'({bus.m_read, bus.m_write}), 32'b00);
    end
    bus.m_busy = 1'b0;
    tick();
    chk("busy release cack", 32'(bus.p_cack), 32'b001);
    chk("busy release m_read", 32'(bus.m_read), 32'd1);
    bus.p_valid = 3'b000;
    tick();
    bus.m_ready = 1'b1;
    bus.m_rdata = 16'h4321;
    tick();
    bus.m_ready = 1'b0;
    chk("busy ready", 32'(bus.p_ready), 32'b001);
    tick();

    // Reset during WAIT of an x read: everything back to reset values, no ready, d wins next.
    bus.p_valid = 3'b100;
    tick();
    chk("rst_x cack", 32'(bus.p_cack), 32'b100);
    bus.p_valid = 3'b000;
    tick();
    rst = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    rst = 1'b1;
    chk("rst ready", 32'(bus.p_ready), 32'b000);
    chk("rst err", 32'(bus.p_err), 32'b000);
    chk("rst cack", 32'(bus.p_cack), 32'b000);
    chk("rst strobes", 32'({bus.m_read, bus.m_write}), 32'b00);
    chk("rst m_addr", 32'(bus.m_addr), 32'h0);
    chk("rst m_wdata", 32'(bus.m_wdata), 32'h0);
    for (int p = 0; p < 3; p++) chk($sformatf("rst rdata%0d", p), 32'(bus.p_rdata[p]), 32'h0);
    tick();
    bus.m_ready = 1'b0;
    chk("rst no stray ready", 32'(bus.p_ready), 32'b000);
    bus.p_valid = 3'b111;
    tick();
    chk("rst d wins", 32'(bus.p_cack), 32'b001);
    bus.p_valid = 3'b000;
    tick();
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    chk("rst d ready", 32'(bus.p_ready), 32'b001);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
